sdp_rd_burst: RTL
=================

# sdp_rd_burst

Burst read initiator for the `sdp` simple dual-port memory. It accepts a command of start address and word count, issues consecutive read addresses on the memory's read-address stream, and collects the returned words. Returned words are re-emitted as an output stream with an end-of-transaction flag on the final word. It sits between a control/sequencer stage and an `sdp` instance's `rd_addr`/`rd_data` pair.

## Interface
Parameters:
- `W_DATA`, 16, memory word width
- `W_ADDR`, 16, memory address width
- `W_LEN`, 16, burst length field width

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd`  dti.consumer  W_LEN+W_ADDR  packed `{len, addr}`, `addr` in LSBs; `len` = number of words to read
- `rd_addr`  dti.producer  W_ADDR  read address to the memory
- `rd_data`  dti.consumer  W_DATA  read data from the memory
- `dout`  dti.producer  W_DATA+1  packed `{eot, data}`, `eot` in MSB

## Operation
- All dti transfers complete on a cycle with `valid & ready`.
- FSM states:
  - IDLE: `cmd.ready`=1, `rd_addr.valid`=0.
    - `cmd` handshake with `len`=0: command consumed, no reads, no output, stay in IDLE.
    - `cmd` handshake with `len`>0: latch `addr` into `cur_addr` and `len` into `len_r`; clear `iss_cnt` and `rcv_cnt`; go to ISSUE.
  - ISSUE: `rd_addr.valid`=1, `rd_addr.data`=`cur_addr`.
    - Each address handshake: `cur_addr`+1 modulo 2^W_ADDR (2^W_ADDR-1 wraps to 0), `iss_cnt`+1.
    - Handshake that makes `iss_cnt`==`len_r`: go to WAIT.
  - WAIT: `rd_addr.valid`=0; wait for the remaining returns.
- Data return path, in ISSUE and WAIT:
  - `dout.data`=`rd_data.data`, `dout.valid`=`rd_data.valid`, `rd_data.ready`=`dout.ready`.
  - `eot`=1 when `rcv_cnt`==`len_r`-1.
  - Each `rd_data` handshake increments `rcv_cnt`.
  - The handshake that makes `rcv_cnt`==`len_r` returns the FSM to IDLE from either ISSUE or WAIT.
- `cmd.ready` is 0 outside IDLE, so only one burst is in flight at a time.
- In IDLE: `rd_data.ready`=1 and `dout.valid`=0. Stray returns, e.g. after reset, are discarded.
- Counters are W_LEN bits; maximum burst is 2^W_LEN-1 words.
- Addresses are issued in strictly increasing order (modulo wrap). Data is forwarded in return order; the memory returns in order.

## Timing
- Reset values:
  - state=IDLE, counters=0.
  - `cmd.ready`=1, `rd_addr.valid`=0, `dout.valid`=0, `dout.eot`=0, `rd_data.ready`=1.
- `cmd` handshake in cycle N → first `rd_addr.valid` in cycle N+1.
- With the `sdp` 1-cycle read latency: first `dout.valid` in cycle N+2.
- `dout.ready` held high → one word per cycle. A burst of L words ends in cycle N+L+1; the next `cmd` can be accepted in cycle N+L+2.
- Backpressure:
  - `dout.ready`=0 stalls `rd_data`; the memory in turn deasserts `rd_addr.ready`.
  - No address or data is lost or duplicated.
  - `rd_addr.data` holds stable while `valid & !ready`.
- Reset asserted mid-burst: next cycle is IDLE with reset values; the remaining words are abandoned.

## Configuration
- Macro `SDP_RD_BURST_OUT_REG_EN`.
- Defined:
  - `dout` is driven from a one-entry register stage (data, eot, valid).
  - `rd_data.ready` = `!dout.valid | dout.ready`.
  - Adds one cycle to the cycle-N figures above: first `dout.valid` in cycle N+3, and the next `cmd` is accepted in cycle N+L+3.
  - Still one word per cycle.
  - Reset clears the register's valid bit.
- Undefined: combinational pass-through as described in Operation.

## Test plan
Memory preloaded with mem[i] = 0x100+i (W_DATA=16, W_ADDR=4).
- `cmd` {len=4, addr=2}, `dout.ready`=1 → `rd_addr` 2,3,4,5 on consecutive cycles; `dout` 0x102..0x105 with `eot` only on 0x105; `cmd.ready` back to 1 after the last word.
- `cmd` {len=3, addr=14} → addresses 14,15,0; `dout` 0x10E, 0x10F, 0x100 with `eot` on 0x100.
- `cmd` {len=0, addr=5} → accepted in 1 cycle; no `rd_addr` or `dout` activity; next `cmd` {len=1, addr=7} → `dout` 0x107 with `eot`=1.
- `cmd` {len=6, addr=0}, `dout.ready` toggled 1,0,0,1,… → exactly 0x100..0x105 in order, `eot` only on 0x105, `rd_addr.data` stable during stalls.
- `cmd` {len=8, addr=0}, `rst` pulsed after the 3rd `dout` word → all outputs at reset values next cycle; no further `dout`; a new `cmd` {len=2, addr=9} yields 0x109, 0x10A.
- With `SDP_RD_BURST_OUT_REG_EN`: `cmd` {len=4, addr=2}, `dout.ready`=1 → same data/eot as the first scenario, first `dout.valid` one cycle later.

Source files
------------

// File: rtl/sdp_rd_burst.sv
`default_nettype none
// ============================================================================
// Module   : sdp_rd_burst
// Purpose  : Burst read initiator for an sdp memory. It issues consecutive
//            read addresses and re-emits the returned words with an eot flag.
// Options  : SDP_RD_BURST_OUT_REG_EN adds a one-entry register stage on dout.
// Revision : 1.0  initial release
// ============================================================================
module sdp_rd_burst #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [W_LEN+W_ADDR-1:0] cmd_data_i,
  output logic                    rd_addr_valid_o,
  input  logic                    rd_addr_ready_i,
  output logic [W_ADDR-1:0]       rd_addr_data_o,
  input  logic                    rd_data_valid_i,
  output logic                    rd_data_ready_o,
  input  logic [W_DATA-1:0]       rd_data_data_i,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i,
  output logic [W_DATA:0]         dout_data_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [W_LEN-1:0]  c_LEN_ONE  = W_LEN'(1);
  localparam logic [W_ADDR-1:0] c_ADDR_ONE = W_ADDR'(1);

  state_e            state_q, state_d;
  logic [W_ADDR-1:0] cur_addr_q, cur_addr_d;
  logic [W_LEN-1:0]  len_q, len_d;
  logic [W_LEN-1:0]  iss_cnt_q, iss_cnt_d;
  logic [W_LEN-1:0]  rcv_cnt_q, rcv_cnt_d;

  logic [W_LEN-1:0]  w_cmd_len;
  logic [W_ADDR-1:0] w_cmd_addr;
  logic [W_LEN-1:0]  w_iss_inc;
  logic [W_LEN-1:0]  w_rcv_inc;
  logic              w_busy;
  logic              w_fwd_ready;
  logic              w_cmd_fire;
  logic              w_addr_fire;
  logic              w_data_fire;
  logic              w_eot;

  assign w_cmd_len  = cmd_data_i[W_LEN+W_ADDR-1:W_ADDR];
  assign w_cmd_addr = cmd_data_i[W_ADDR-1:0];
  assign w_iss_inc  = iss_cnt_q + c_LEN_ONE;
  assign w_rcv_inc  = rcv_cnt_q + c_LEN_ONE;
  assign w_busy     = (state_q != S_IDLE);

`ifdef SDP_RD_BURST_OUT_REG_EN
  logic              out_valid_q;
  logic [W_DATA:0]   out_data_q;

  // The next command waits until the final word has left the output register.
  assign w_fwd_ready = !out_valid_q || dout_ready_i;
  assign cmd_ready_o = (state_q == S_IDLE) && !out_valid_q;
`else
  assign w_fwd_ready = dout_ready_i;
  assign cmd_ready_o = (state_q == S_IDLE);
`endif

  assign rd_addr_valid_o = (state_q == S_ISSUE);
  assign rd_addr_data_o  = cur_addr_q;
  // Returns arriving while idle are strays and are simply drained.
  assign rd_data_ready_o = w_busy ? w_fwd_ready : 1'b1;

  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_addr_fire = rd_addr_valid_o && rd_addr_ready_i;
  assign w_data_fire = w_busy && rd_data_valid_i && w_fwd_ready;
  assign w_eot       = w_busy && (rcv_cnt_q == (len_q - c_LEN_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      len_q      <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_cmd_fire && (w_cmd_len != '0)) begin
          cur_addr_d = w_cmd_addr;
          len_d      = w_cmd_len;
          iss_cnt_d  = '0;
          rcv_cnt_d  = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_addr_fire) begin
          cur_addr_d = cur_addr_q + c_ADDR_ONE;
          iss_cnt_d  = w_iss_inc;
          if (w_iss_inc == len_q) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The final return ends the burst from either ISSUE or WAIT.
    if (w_data_fire) begin
      rcv_cnt_d = w_rcv_inc;
      if (w_rcv_inc == len_q) begin
        state_d = S_IDLE;
      end
    end
  end

`ifdef SDP_RD_BURST_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (w_fwd_ready) begin
        out_valid_q <= w_data_fire;
      end
      if (w_data_fire) begin
        out_data_q <= {w_eot, rd_data_data_i};
      end
    end
  end

  assign dout_valid_o = out_valid_q;
  assign dout_data_o  = out_data_q;
`else
  assign dout_valid_o = w_busy && rd_data_valid_i;
  assign dout_data_o  = {w_eot, rd_data_data_i};
`endif

endmodule
`default_nettype wire
